// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard / stall control slice.
package hazard_pkg;

  localparam int unsigned REG_W = 5;

  // Architectural zero register: never a real dependency.
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_wait_state_t;

  // Pipeline-register hold/clear controls, one bit per named control.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
  } pipe_ctrl_t;

  // Priority resolution: memory wait, then taken branch, then load-use.
  function automatic pipe_ctrl_t resolve_ctrl(
    input logic mem_stall,
    input logic branch_taken,
    input logic load_use
  );
    pipe_ctrl_t c;
    c = '0;
    if (mem_stall) begin
      // Whole pipe freezes; branch/load-use wait until E is released.
      c.stall_f = 1'b1;
      c.stall_d = 1'b1;
      c.stall_e = 1'b1;
      c.stall_m = 1'b1;
    end else if (branch_taken) begin
      // Squash the two wrong-path instructions behind the branch.
      c.flush_d = 1'b1;
      c.flush_e = 1'b1;
    end else if (load_use) begin
      // Hold F/D one cycle and inject a bubble into E.
      c.stall_f = 1'b1;
      c.stall_d = 1'b1;
      c.flush_e = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Tracks multi-cycle data-memory waits and raises a sticky timeout flag.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic memStall,
  input  logic MemReqM,
  input  logic MemReadyM,
  output logic MemTimeout
);

  // CNT_W must be wide enough that the limit is reachable: 2^CNT_W > MAX_WAIT.
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WAIT);

  mem_wait_state_t  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  logic w_release;
  logic w_at_limit;

  // The access ends when memory answers or the request goes away.
  assign w_release  = MemReadyM | ~MemReqM;
  assign w_at_limit = (r_state == WAIT) & ~w_release & (r_cnt == CNT_LIMIT);

  // Wait state, saturating wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_at_limit) begin
        r_timeout <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (memStall) begin
            r_state <= WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (w_release) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign MemTimeout = r_timeout;

endmodule

// File: rtl/hazard_stall_unit.sv
// MEM/WB destination tracking for forwarding plus pipeline stall/flush control.
module hazard_stall_unit #(
  parameter int unsigned REG_W    = hazard_pkg::REG_W,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] RdE,
  input  logic             RegWriteE,
  input  logic             IsLoadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [REG_W-1:0] RdM,
  output logic [REG_W-1:0] RdW,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MemTimeout
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(hazard_pkg::ZERO_REG);

  logic w_mem_stall;
  logic w_load_use;
  logic w_rd_nonzero;
  logic w_src_match;

  hazard_pkg::pipe_ctrl_t w_ctrl_raw;
  hazard_pkg::pipe_ctrl_t w_ctrl;

  logic [REG_W-1:0] r_rd_m;
  logic [REG_W-1:0] r_rd_w;
  logic             r_regwrite_m;
  logic             r_regwrite_w;

  // Zero-latency memory stall: request outstanding and not yet answered.
  assign w_mem_stall = MemReqM & ~MemReadyM;

  // Load in E feeding an operand of the instruction in D.
  assign w_rd_nonzero = (RdE != ZERO_IDX);
  assign w_src_match  = (RdE == Rs1D) | (RdE == Rs2D);
  assign w_load_use   = IsLoadE & RegWriteE & w_rd_nonzero & w_src_match;

  // Prioritised controls, forced quiet while reset is asserted.
  assign w_ctrl_raw = hazard_pkg::resolve_ctrl(w_mem_stall, PCSrcE, w_load_use);
  assign w_ctrl     = rst_n ? w_ctrl_raw : '0;

  assign StallF = w_ctrl.stall_f;
  assign StallD = w_ctrl.stall_d;
  assign StallE = w_ctrl.stall_e;
  assign StallM = w_ctrl.stall_m;
  assign FlushD = w_ctrl.flush_d;
  assign FlushE = w_ctrl.flush_e;

  // MEM tracking: follow E unless MEM is held; E-bubbles arrive via RegWriteE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_m       <= '0;
      r_regwrite_m <= 1'b0;
    end else if (!w_ctrl.stall_m) begin
      r_rd_m       <= RdE;
      r_regwrite_m <= RegWriteE;
    end
  end

  // WB tracking: bubble into WB while memory stalls, otherwise follow MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_w       <= '0;
      r_regwrite_w <= 1'b0;
    end else if (w_mem_stall) begin
      r_regwrite_w <= 1'b0;
    end else begin
      r_rd_w       <= r_rd_m;
      r_regwrite_w <= r_regwrite_m;
    end
  end

  assign RdM       = r_rd_m;
  assign RdW       = r_rd_w;
  assign RegWriteM = r_regwrite_m;
  assign RegWriteW = r_regwrite_w;

  // Wait-duration tracking and timeout detection.
  mem_wait_fsm #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_mem_wait_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .memStall   (w_mem_stall),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .MemTimeout (MemTimeout)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: vector table, corner sequences, random vs model.
module tb_hazard_stall_unit;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned MAX_WAIT = 15;
  localparam int unsigned CNT_W    = 4;

  logic             clk;
  logic             rst_n;
  logic [REG_W-1:0] Rs1D, Rs2D, RdE;
  logic             RegWriteE, IsLoadE, PCSrcE, MemReqM, MemReadyM;
  logic [REG_W-1:0] RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeout;

  int checks;
  int errors;

  // Reference model state: tracked registers, current stall-run length, sticky flag.
  logic [REG_W-1:0] m_rdm, m_rdw;
  logic             m_rwm, m_rww, m_to;
  int               m_run;

  typedef struct {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rde;
    logic             rwe;
    logic             ld;
    logic             br;
    logic             req;
    logic             rdy;
    logic [5:0]       exp; // {StallF,StallD,StallE,StallM,FlushD,FlushE}
  } vec_t;

  vec_t vecs[12];

  hazard_stall_unit #(
    .REG_W    (REG_W),
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdE        (RdE),
    .RegWriteE  (RegWriteE),
    .IsLoadE    (IsLoadE),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .MemTimeout (MemTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] ctrl_act();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE};
  endfunction

  function automatic logic [11:0] track_act();
    return {RdM, RegWriteM, RdW, RegWriteW};
  endfunction

  // Expected controls straight from the hazard rules and their priority.
  function automatic logic [5:0] exp_ctrl();
    logic ms, lu;
    ms = MemReqM && !MemReadyM;
    lu = IsLoadE && RegWriteE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    if (!rst_n) return 6'b000000;
    if (ms)     return 6'b111100;
    if (PCSrcE) return 6'b000011;
    if (lu)     return 6'b110001;
    return 6'b000000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("ctrl", 32'(ctrl_act()), 32'(exp_ctrl()));
    check("track", 32'(track_act()), 32'({m_rdm, m_rwm, m_rdw, m_rww}));
    check("timeout", 32'(MemTimeout), 32'(m_to));
  endtask

  task automatic model_reset();
    m_rdm = '0; m_rdw = '0; m_rwm = 1'b0; m_rww = 1'b0; m_to = 1'b0; m_run = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    logic ms;
    ms = MemReqM && !MemReadyM;
    if (ms && (m_run >= int'(MAX_WAIT))) m_to = 1'b1;
    m_run = ms ? m_run + 1 : 0;
    if (ms) begin
      m_rww = 1'b0;
    end else begin
      m_rdw = m_rdm;
      m_rww = m_rwm;
      m_rdm = RdE;
      m_rwm = RegWriteE;
    end
  endtask

  // Entered at posedge+1: drive inputs, settle, compare against the model.
  task automatic apply(input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                       input logic [REG_W-1:0] rde, input logic rwe, input logic ld,
                       input logic br, input logic req, input logic rdy);
    Rs1D = rs1; Rs2D = rs2; RdE = rde; RegWriteE = rwe; IsLoadE = ld;
    PCSrcE = br; MemReqM = req; MemReadyM = rdy;
    #2;
    check_model();
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Async reset between edges with inputs still active; everything must drop at once.
  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    check("rst_ctrl", 32'(ctrl_act()), 32'h0);
    check("rst_track", 32'(track_act()), 32'h0);
    check("rst_timeout", 32'(MemTimeout), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle();
    apply('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_cycle(input logic [REG_W-1:0] rde);
    apply('0, '0, rde, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  int burst;

  initial begin
    checks = 0;
    errors = 0;
    model_reset();

    // Reset with every hazard source active: controls gated to zero.
    rst_n = 1'b0;
    Rs1D = 5'd5; Rs2D = 5'd5; RdE = 5'd5; RegWriteE = 1'b1; IsLoadE = 1'b1;
    PCSrcE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
    #2;
    check("init_ctrl", 32'(ctrl_act()), 32'h0);
    check("init_track", 32'(track_act()), 32'h0);
    check("init_timeout", 32'(MemTimeout), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-cycle control vectors.
    vecs[0]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110001};
    vecs[1]  = '{5'd3, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110001};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[3]  = '{5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[4]  = '{5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[5]  = '{5'd6, 5'd7, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[6]  = '{5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000011};
    vecs[7]  = '{5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'b111100};
    vecs[8]  = '{5'd8, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'b110001};
    vecs[9]  = '{5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};
    vecs[10] = '{5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b111100};
    vecs[11] = '{5'd31, 5'd4, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b110001};
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].rs1, vecs[i].rs2, vecs[i].rde, vecs[i].rwe, vecs[i].ld,
            vecs[i].br, vecs[i].req, vecs[i].rdy);
      check($sformatf("vec%0d_ctrl", i), 32'(ctrl_act()), 32'(vecs[i].exp));
      tick();
    end

    // Load-use: one stall cycle, then the load sits in MEM.
    apply(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_ctrl", 32'(ctrl_act()), 32'(6'b110001));
    tick();
    check("lu_rdm", 32'(RdM), 32'd5);
    check("lu_rwm", 32'(RegWriteM), 32'd1);

    // Three-cycle memory wait: pipe frozen, MEM held, WB bubbled.
    apply('0, '0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    apply('0, '0, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      wait_cycle(5'd25);
      check("mw_ctrl", 32'(ctrl_act()), 32'(6'b111100));
      check("mw_rdm", 32'(RdM), 32'd20);
      if (i > 0) check("mw_rww", 32'(RegWriteW), 32'd0);
      tick();
    end
    apply('0, '0, 5'd25, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mw_release", 32'(ctrl_act()), 32'h0);
    tick();
    check("mw_after", 32'(track_act()), 32'({5'd25, 1'b1, 5'd20, 1'b1}));

    // Reset asserted during a wait with WB holding r7.
    apply('0, '0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    apply('0, '0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    wait_cycle(5'd7);
    check("rw_pre", 32'({RdW, RegWriteW}), 32'({5'd7, 1'b1}));
    mid_reset();

    // Back-to-back waits restart the count; only a >MAX_WAIT wait times out.
    for (int i = 0; i < 10; i++) begin wait_cycle(5'd1); tick(); end
    apply('0, '0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin wait_cycle(5'd1); tick(); end
    check("b2b_no_to", 32'(MemTimeout), 32'd0);
    apply('0, '0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 15; i++) begin wait_cycle(5'd1); tick(); end
    check("to_15", 32'(MemTimeout), 32'd0);
    wait_cycle(5'd1);
    check("to_stall_on", 32'(ctrl_act()), 32'(6'b111100));
    tick();
    check("to_16", 32'(MemTimeout), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("to_sticky", 32'(MemTimeout), 32'd1);
      tick();
    end
    idle();
    mid_reset();

    // Randomised traffic with occasional long waits and resets.
    burst = 0;
    for (int n = 0; n < 500; n++) begin
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = int'($urandom_range(8, 20));
      if (burst > 0) begin
        burst--;
        apply(REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7)),
              REG_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end else begin
        apply(REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7)),
              REG_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 6) == 0),
              ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 149) == 0) begin
        mid_reset();
        burst = 0;
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
